// File: rtl/rc_tdc_scan_if.sv
// Control and result-stream bundle for rc_tdc_scan.
// The converter drives the master side; the consumer or sequencer drives the slave side.
interface rc_tdc_scan_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 24
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                start;
    logic                continuous;
    logic [CHANNELS-1:0] chan_en;
    logic                busy;
    logic                sweep_done;

    // Result stream: a word moves on any rising clk edge with result_valid && result_ready.
    // Once result_valid is high, it and every result_* field hold until that edge.
    // result_valid never depends on result_ready.
    logic                result_valid;
    logic                result_ready;
    logic [CNT_W-1:0]    result_count;
    logic [CH_W-1:0]     result_chan;
    logic [1:0]          result_status;

    modport master (
        input  start, continuous, chan_en, result_ready,
        output busy, sweep_done, result_valid, result_count, result_chan, result_status
    );

    modport slave (
        output start, continuous, chan_en, result_ready,
        input  busy, sweep_done, result_valid, result_count, result_chan, result_status
    );
endinterface

// File: rtl/rc_tdc_scan.sv
// Multi-channel RC time-to-digital converter: charge each enabled channel in turn, count cycles
// to threshold, enforce a discharge interval and stream one raw count per channel.
module rc_tdc_scan #(
    parameter int               CHANNELS         = 4,
    parameter int               CNT_W            = 24,
    parameter logic [CNT_W-1:0] MAX_COUNT        = {CNT_W{1'b1}},
    parameter int               DISCHARGE_CYCLES = 1024,
    parameter int               SYNC_STAGES      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    rc_tdc_scan_if.master        bus,
    input  logic [CHANNELS-1:0]  step_in,
    output logic [CHANNELS-1:0]  step_out,
    output logic [1:0]           state_dbg
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DIS_W = $clog2(DISCHARGE_CYCLES + 1);
    localparam logic [DIS_W-1:0] DIS_LAST = DIS_W'(DISCHARGE_CYCLES);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_CHARGE    = 2'd1;
    localparam logic [1:0] S_DISCHARGE = 2'd2;
    localparam logic [1:0] S_HOLD      = 2'd3;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_STUCK   = 2'b10;

    logic [1:0]          state_q;
    logic [CH_W-1:0]     ch_q;
    logic [CHANNELS-1:0] mask_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DIS_W-1:0]    dis_q;
    logic                done_q;
    logic                valid_q;
    logic [CNT_W-1:0]    res_count_q;
    logic [CH_W-1:0]     res_chan_q;
    logic [1:0]          res_status_q;

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];

    logic [CH_W:0]   first_start;
    logic [CH_W:0]   first_mask;
    logic [CH_W:0]   next_mask;
    logic            sync_sel;
    logic            consumed;
    logic [1:0]      adv_state;
    logic [CH_W-1:0] adv_ch;
    logic            adv_done;

    // Returns {found, index} of the lowest set bit of m strictly above position 'above'.
    function automatic logic [CH_W:0] lowest_set(input logic [CHANNELS-1:0] m, input int above);
        logic [CH_W:0] r;
        r = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (m[i] && (i > above)) r = {1'b1, CH_W'(i)};
        end
        return r;
    endfunction

    // Free-running synchronisers on every pad; only the selected channel is consulted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) sync_q[i] <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++)
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], step_in[i]};
        end
    end

    always_comb begin
        first_start = lowest_set(bus.chan_en, -1);
        first_mask  = lowest_set(mask_q, -1);
        next_mask   = lowest_set(mask_q, int'(ch_q));
        sync_sel    = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(ch_q) == i) sync_sel = sync_q[i][SYNC_STAGES-1];
        end
        // A result transferring on this edge counts as consumed, so the next charge can begin.
        consumed = !valid_q || bus.result_ready;
    end

    // Where the sweep goes once the current channel is finished and its result is taken.
    always_comb begin
        adv_state = S_IDLE;
        adv_ch    = ch_q;
        adv_done  = 1'b0;
        if (next_mask[CH_W]) begin
            adv_state = S_CHARGE;
            adv_ch    = next_mask[CH_W-1:0];
        end else begin
            adv_done = 1'b1;
            if (bus.continuous) begin
                adv_state = S_CHARGE;
                adv_ch    = first_mask[CH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ch_q         <= '0;
            mask_q       <= '0;
            cnt_q        <= '0;
            dis_q        <= '0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            res_count_q  <= '0;
            res_chan_q   <= '0;
            res_status_q <= ST_OK;
        end else begin
            done_q <= 1'b0;
            if (valid_q && bus.result_ready) valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // done_q marks the final busy cycle of a sweep; a start there is ignored.
                    if (bus.start && !done_q && first_start[CH_W]) begin
                        mask_q  <= bus.chan_en;
                        ch_q    <= first_start[CH_W-1:0];
                        cnt_q   <= '0;
                        state_q <= S_CHARGE;
                    end
                end

                S_CHARGE: begin
                    if (sync_sel || (cnt_q == MAX_COUNT)) begin
                        res_count_q  <= cnt_q;
                        res_chan_q   <= ch_q;
                        res_status_q <= !sync_sel ? ST_TIMEOUT :
                                        (cnt_q == '0) ? ST_STUCK : ST_OK;
                        valid_q      <= 1'b1;
                        dis_q        <= '0;
                        state_q      <= S_DISCHARGE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                S_DISCHARGE: begin
                    if (dis_q == DIS_LAST) begin
                        if (consumed) begin
                            state_q <= adv_state;
                            ch_q    <= adv_ch;
                            cnt_q   <= '0;
                            done_q  <= adv_done;
                        end else begin
                            state_q <= S_HOLD;
                        end
                    end else begin
                        dis_q <= dis_q + DIS_W'(1);
                    end
                end

                default: begin
                    if (consumed) begin
                        state_q <= adv_state;
                        ch_q    <= adv_ch;
                        cnt_q   <= '0;
                        done_q  <= adv_done;
                    end
                end
            endcase
        end
    end

    // Decoded from registers, so an asynchronous reset releases the pads at once.
    always_comb begin
        step_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            step_out[i] = (state_q == S_CHARGE) && (int'(ch_q) == i);
        end
    end

    assign bus.busy          = (state_q != S_IDLE) || done_q;
    assign bus.sweep_done    = done_q;
    assign bus.result_valid  = valid_q;
    assign bus.result_count  = res_count_q;
    assign bus.result_chan   = res_chan_q;
    assign bus.result_status = res_status_q;
    assign state_dbg         = state_q;
endmodule
